muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//   Sequences the shared multi-cycle multiply/divide datapath. It accepts one MULTU or DIVU
//   request, then drives the datapath's reset, Signal and OUT codes. It captures the 64-bit
//   result into the HI/LO registers and serves MFHI/MFLO reads.
//   Sits between the ALU control decode and the Multiplier/Divider datapath.
// PARAMETERS
//   WIDTH   32  operand width; HI and LO are WIDTH bits each, dp_data is 2*WIDTH bits
//   CYCLES  32  number of iteration cycles the datapath needs per operation (>=1)
// PORTS
//   clk        in   1        clock; all state updates on rising edge
//   reset      in   1        asynchronous, active-high reset
//   start      in   1        request strobe; sampled only in IDLE
//   op_code    in   6        funct: MULTU=6'b011001, DIVU=6'b011011, MFHI=6'b010000, MFLO=6'b010010
//   dp_data    in   2*WIDTH  datapath result (dataOut): [2W-1:W] -> HI, [W-1:0] -> LO
//   dp_reset   out  1        datapath clear/load strobe
//   dp_signal  out  6        datapath operation code
//   busy       out  1        high from the cycle after start is accepted until done
//   done       out  1        one-cycle pulse; HI/LO written at the end of this cycle
//   hi_out     out  WIDTH    HI register
//   lo_out     out  WIDTH    LO register
//   rd_out     out  WIDTH    op_code==MFHI ? HI : op_code==MFLO ? LO : 0 (combinational)
//   abort      in   1        present only when MULDIV_ABORT_EN is defined
// BEHAVIOUR
//   FSM states: IDLE -> LOAD -> RUN -> FLUSH -> WRITE -> IDLE.
//   - IDLE:  start && op_code in {MULTU,DIVU} -> latch op into op_q and go to LOAD.
//            Any other op_code with start is ignored and the FSM stays in IDLE.
//   - LOAD:  one cycle; dp_reset=1, dp_signal=0; clear cnt -> RUN.
//   - RUN:   dp_signal=op_q for exactly CYCLES cycles; cnt increments each cycle;
//            cnt==CYCLES-1 -> FLUSH.
//   - FLUSH: one cycle; dp_signal=6'b111111 (OUT).
//   - WRITE: one cycle; done=1; HI<=dp_data[2W-1:W], LO<=dp_data[W-1:0] -> IDLE.
//   Outputs per state:
//   - dp_reset=1 only in LOAD. dp_signal=0 in IDLE and WRITE.
//   - busy=1 in LOAD, RUN, FLUSH and WRITE.
//   Timing: start sampled at edge 0; LOAD is cycle 1; RUN is cycles 2..CYCLES+1;
//   FLUSH is cycle CYCLES+2; done is high in cycle CYCLES+3. New HI/LO values are visible
//   from cycle CYCLES+4, and a new start is accepted in that same cycle.
//   Result mapping is the same for both ops: MULTU product {hi,lo}; DIVU {remainder,quotient}.
//   start while busy is ignored, with no queueing; op_code changes while busy have no effect.
//   MFHI/MFLO while busy: rd_out returns the previous HI/LO (no stall generated here).
//   cnt is $clog2(CYCLES)+1 bits wide and must never wrap within RUN.
//   Reset (async, any state, including mid-RUN): state=IDLE, cnt=0, op_q=0, HI=LO=0.
//   All outputs go to 0 immediately: busy, done, dp_reset, dp_signal.
// CONFIGURATION
//   MULDIV_ABORT_EN defined: the abort port exists.
//   - abort=1 in LOAD/RUN/FLUSH -> next state IDLE; dp_reset=1 in that abort cycle.
//   - HI/LO unchanged; no done pulse.
//   - abort is ignored in IDLE and WRITE; abort with start in IDLE -> start wins.
//   MULDIV_ABORT_EN undefined: the abort port is absent and every accepted op runs to WRITE.
// TESTING  (datapath replaced by a stub driving dp_data)
//   1 Reset: assert reset mid-clock -> all outputs 0 without waiting for clk.
//   2 MULTU: start with op=6'b011001, stub dp_data=64'h00000001_0000000F.
//     -> dp_reset=1 in cycle 1; dp_signal=25 for 32 cycles; 63 in cycle 34; done in cycle 35.
//     -> hi_out=1, lo_out=15.
//   3 DIVU (op=27), stub 64'h00000002_00000007 -> done in cycle 35;
//     then op=MFHI gives rd_out=2 and op=MFLO gives rd_out=7.
//   4 Start with op=6'b010000 in IDLE -> busy stays 0 and HI/LO unchanged.
//     Start pulsed in cycle 10 of RUN -> ignored; exactly one done pulse.
//   5 Async reset in RUN cycle 10 -> state IDLE, HI/LO=0, no done.
//     Next start -> full 35-cycle sequence.
//   6 (MULDIV_ABORT_EN) abort in RUN cycle 5 -> dp_reset=1 that cycle, IDLE next.
//     HI/LO hold prior values; no done.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Control sequencer for the shared multi-cycle MULTU/DIVU datapath; owns HI/LO and MFHI/MFLO reads.
// Optional feature: define MULDIV_ABORT_EN to add the abort input.
module muldiv_sequencer #(
    parameter int WIDTH  = 32,
    parameter int CYCLES = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [5:0]           op_code,
    input  logic [2*WIDTH-1:0]   dp_data,
`ifdef MULDIV_ABORT_EN
    input  logic                 abort,
`endif
    output logic                 dp_reset,
    output logic [5:0]           dp_signal,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     hi_out,
    output logic [WIDTH-1:0]     lo_out,
    output logic [WIDTH-1:0]     rd_out
);

    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIVU  = 6'b011011;
    localparam logic [5:0] OP_MFHI  = 6'b010000;
    localparam logic [5:0] OP_MFLO  = 6'b010010;
    localparam logic [5:0] SIG_OUT  = 6'b111111;

    localparam int CW = $clog2(CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_FLUSH = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [5:0]        r_op_q;
    logic [WIDTH-1:0]  r_hi;
    logic [WIDTH-1:0]  r_lo;
    logic              r_dp_reset;
    logic [5:0]        r_dp_signal;
    logic              r_busy;
    logic              r_done;
    logic              w_abort;
    logic              w_start_ok;

    assign w_start_ok = start && ((op_code == OP_MULTU) || (op_code == OP_DIVU));

`ifdef MULDIV_ABORT_EN
    assign w_abort = abort && ((r_state == S_LOAD) || (r_state == S_RUN) || (r_state == S_FLUSH));
`else
    assign w_abort = 1'b0;
`endif

    // Sequencer FSM with registered datapath controls and HI/LO capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_op_q      <= 6'd0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_dp_reset  <= 1'b0;
            r_dp_signal <= 6'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else if (w_abort) begin
            // Abandon the operation; HI/LO keep their previous contents.
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_dp_reset  <= 1'b0;
            r_dp_signal <= 6'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_state     <= S_LOAD;
                        r_op_q      <= op_code;
                        r_dp_reset  <= 1'b1;
                        r_dp_signal <= 6'd0;
                        r_busy      <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                    r_done <= 1'b0;
                end
                S_LOAD: begin
                    r_state     <= S_RUN;
                    r_cnt       <= '0;
                    r_dp_reset  <= 1'b0;
                    r_dp_signal <= r_op_q;
                end
                S_RUN: begin
                    if (r_cnt == CNT_LAST) begin
                        r_state     <= S_FLUSH;
                        r_dp_signal <= SIG_OUT;
                    end else begin
                        r_state <= S_RUN;
                    end
                    r_cnt <= r_cnt + CW'(1);
                end
                S_FLUSH: begin
                    r_state     <= S_WRITE;
                    r_dp_signal <= 6'd0;
                    r_done      <= 1'b1;
                end
                S_WRITE: begin
                    r_state <= S_IDLE;
                    r_hi    <= dp_data[2*WIDTH-1:WIDTH];
                    r_lo    <= dp_data[WIDTH-1:0];
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cnt       <= '0;
                    r_dp_reset  <= 1'b0;
                    r_dp_signal <= 6'd0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

    // The abort cycle itself must already clear the datapath, so it bypasses the register.
    assign dp_reset  = r_dp_reset | w_abort;
    assign dp_signal = r_dp_signal;
    assign busy      = r_busy;
    assign done      = r_done;
    assign hi_out    = r_hi;
    assign lo_out    = r_lo;

    // Move-from-HI/LO read port.
    always_comb begin
        rd_out = '0;
        if (op_code == OP_MFHI) begin
            rd_out = r_hi;
        end else if (op_code == OP_MFLO) begin
            rd_out = r_lo;
        end else begin
            rd_out = '0;
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer with a stub datapath driving dp_data.
module tb_muldiv_sequencer;

    localparam int W   = 32;
    localparam int CYC = 32;
    localparam logic [5:0] MULTU = 6'b011001;
    localparam logic [5:0] DIVU  = 6'b011011;
    localparam logic [5:0] MFHI  = 6'b010000;
    localparam logic [5:0] MFLO  = 6'b010010;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic [5:0]     op_code = 6'd0;
    logic [2*W-1:0] dp_data = '0;
    logic           abort = 1'b0;
    logic           dp_reset;
    logic [5:0]     dp_signal;
    logic           busy;
    logic           done;
    logic [W-1:0]   hi_out;
    logic [W-1:0]   lo_out;
    logic [W-1:0]   rd_out;

    int checks = 0;
    int errors = 0;

    muldiv_sequencer #(.WIDTH(W), .CYCLES(CYC)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op_code   (op_code),
        .dp_data   (dp_data),
`ifdef MULDIV_ABORT_EN
        .abort     (abort),
`endif
        .dp_reset  (dp_reset),
        .dp_signal (dp_signal),
        .busy      (busy),
        .done      (done),
        .hi_out    (hi_out),
        .lo_out    (lo_out),
        .rd_out    (rd_out)
    );

    always #5 clk = ~clk;

    // Drives a start pulse; returns at the negedge of cycle 1.
    task automatic issue(input logic [5:0] op);
        @(negedge clk);
        op_code = op;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic test_reset;
        issue(MULTU);
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({dp_reset, dp_signal, busy, done} !== 9'd0 || hi_out !== 32'd0 || lo_out !== 32'd0) begin
            errors++;
            $display("FAIL reset_async: dp_reset=%b dp_signal=%0d busy=%b done=%b hi=%h lo=%h, want all 0",
                     dp_reset, dp_signal, busy, done, hi_out, lo_out);
        end
        @(negedge clk);
        reset = 1'b0;
        op_code = MFHI;
        #1;
        checks++;
        if (rd_out !== 32'd0) begin
            errors++;
            $display("FAIL reset_rd: rd_out=%h want 0", rd_out);
        end
    endtask

    task automatic test_multu;
        logic       e_rst;
        logic [5:0] e_sig;
        logic       e_busy;
        logic       e_done;
        dp_data = 64'h00000001_0000000F;
        issue(MULTU);
        for (int c = 1; c <= 36; c++) begin
            e_rst  = (c == 1);
            e_sig  = (c >= 2 && c <= CYC + 1) ? MULTU : ((c == CYC + 2) ? 6'd63 : 6'd0);
            e_busy = (c >= 1 && c <= CYC + 3);
            e_done = (c == CYC + 3);
            checks++;
            if ({dp_reset, dp_signal, busy, done} !== {e_rst, e_sig, e_busy, e_done}) begin
                errors++;
                $display("FAIL multu_cycle%0d: rst=%b sig=%0d busy=%b done=%b want rst=%b sig=%0d busy=%b done=%b",
                         c, dp_reset, dp_signal, busy, done, e_rst, e_sig, e_busy, e_done);
            end
            if (c < 36) @(negedge clk);
        end
        checks++;
        if (hi_out !== 32'd1 || lo_out !== 32'd15) begin
            errors++;
            $display("FAIL multu_result: hi=%h lo=%h want 1 / f", hi_out, lo_out);
        end
    endtask

    task automatic test_divu;
        int done_cyc;
        done_cyc = 0;
        dp_data = 64'h00000002_00000007;
        issue(DIVU);
        op_code = MFHI;
        for (int c = 1; c <= 36; c++) begin
            if (done === 1'b1) done_cyc = c;
            if (c == 10) begin
                checks++;
                if (rd_out !== 32'd1 || dp_signal !== DIVU) begin
                    errors++;
                    $display("FAIL divu_busy_read: rd_out=%h sig=%0d want 1 / %0d", rd_out, dp_signal, DIVU);
                end
            end
            if (c < 36) @(negedge clk);
        end
        checks++;
        if (done_cyc != CYC + 3) begin
            errors++;
            $display("FAIL divu_done_cycle: got %0d want %0d", done_cyc, CYC + 3);
        end
        checks++;
        if (rd_out !== 32'd2) begin
            errors++;
            $display("FAIL divu_mfhi: rd_out=%h want 2", rd_out);
        end
        op_code = MFLO;
        #1;
        checks++;
        if (rd_out !== 32'd7) begin
            errors++;
            $display("FAIL divu_mflo: rd_out=%h want 7", rd_out);
        end
    endtask

    task automatic test_ignored_start;
        int n_done;
        int done_cyc;
        int busy_seen;
        busy_seen = 0;
        issue(MFHI);
        for (int c = 0; c < 5; c++) begin
            if (busy !== 1'b0) busy_seen++;
            @(negedge clk);
        end
        checks++;
        if (busy_seen != 0 || hi_out !== 32'd2 || lo_out !== 32'd7) begin
            errors++;
            $display("FAIL nonmuldiv_start: busy cycles=%0d hi=%h lo=%h want 0 / 2 / 7", busy_seen, hi_out, lo_out);
        end
        n_done = 0;
        done_cyc = 0;
        dp_data = 64'h0000000A_0000000B;
        issue(MULTU);
        for (int c = 1; c <= 45; c++) begin
            if (done === 1'b1) begin
                n_done++;
                done_cyc = c;
            end
            start = (c == 11);
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (n_done != 1 || done_cyc != CYC + 3) begin
            errors++;
            $display("FAIL busy_start: done pulses=%0d at cycle %0d want 1 at %0d", n_done, done_cyc, CYC + 3);
        end
        checks++;
        if (hi_out !== 32'hA || lo_out !== 32'hB || busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_result: hi=%h lo=%h busy=%b want a / b / 0", hi_out, lo_out, busy);
        end
    endtask

    task automatic test_reset_mid_run;
        int n_done;
        int done_cyc;
        dp_data = 64'h00000003_00000004;
        issue(DIVU);
        repeat (10) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || dp_signal !== 6'd0 || hi_out !== 32'd0 || lo_out !== 32'd0) begin
            errors++;
            $display("FAIL run_reset: busy=%b sig=%0d hi=%h lo=%h want 0", busy, dp_signal, hi_out, lo_out);
        end
        @(negedge clk);
        reset = 1'b0;
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            if (done === 1'b1 || busy === 1'b1) n_done++;
            @(negedge clk);
        end
        checks++;
        if (n_done != 0) begin
            errors++;
            $display("FAIL run_reset_idle: active cycles=%0d want 0", n_done);
        end
        done_cyc = 0;
        issue(MULTU);
        for (int c = 1; c <= 36; c++) begin
            if (done === 1'b1) done_cyc = c;
            if (c < 36) @(negedge clk);
        end
        checks++;
        if (done_cyc != CYC + 3 || hi_out !== 32'd3 || lo_out !== 32'd4) begin
            errors++;
            $display("FAIL rerun_after_reset: done cycle=%0d hi=%h lo=%h want %0d / 3 / 4",
                     done_cyc, hi_out, lo_out, CYC + 3);
        end
    endtask

`ifdef MULDIV_ABORT_EN
    task automatic test_abort;
        int n_done;
        dp_data = 64'h00000055_00000066;
        issue(MULTU);
        repeat (5) @(negedge clk);
        abort = 1'b1;
        #1;
        checks++;
        if (dp_reset !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_cycle: dp_reset=%b busy=%b want 1 / 1", dp_reset, busy);
        end
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || dp_signal !== 6'd0 || dp_reset !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b sig=%0d rst=%b want 0", busy, dp_signal, dp_reset);
        end
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            if (done === 1'b1) n_done++;
            @(negedge clk);
        end
        checks++;
        if (n_done != 0 || hi_out !== 32'd3 || lo_out !== 32'd4) begin
            errors++;
            $display("FAIL abort_hold: done pulses=%0d hi=%h lo=%h want 0 / 3 / 4", n_done, hi_out, lo_out);
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        test_reset;
        test_multu;
        test_divu;
        test_ignored_start;
        test_reset_mid_run;
`ifdef MULDIV_ABORT_EN
        test_abort;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
